// File: rtl/gnrl_fifo_buf.sv
// -----------------------------------------------------------------------------
// gnrl_fifo_buf
//   Parameterised synchronous FIFO built from load-enable flop storage.
//   Valid/ready elastic buffer with fully decoupled sides: i_rdy and o_vld
//   both come from the registered occupancy count only. There is no
//   combinational path from i_vld to o_vld, or from o_rdy to i_rdy.
//
// Parameters
//   DP : depth in entries (>= 1, any value)
//   DW : data width in bits
//   CW : occupancy count width, derived from DP (do not override)
//
// Ports
//   clk   in  1   clock, rising edge
//   rstn  in  1   asynchronous active-low reset
//   flush in  1   synchronous clear of all entries (wins over push/pop)
//   i_vld in  1   upstream data valid
//   i_rdy out 1   FIFO can accept (not full)
//   i_dat in  DW  write data
//   o_vld out 1   head entry valid (not empty)
//   o_rdy in  1   downstream accepts head entry
//   o_dat out DW  head entry data
//   count out CW  occupied entries, 0..DP
// -----------------------------------------------------------------------------

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
// Simulation-only checker: control inputs must be known while out of reset,
// and the occupancy must never exceed the depth.
module gnrl_fifo_buf_chk #(
  parameter int DP = 4,
  parameter int CW = $clog2(DP + 1)
) (
  input logic          clk,
  input logic          rstn,
  input logic          i_vld,
  input logic          o_rdy,
  input logic          flush,
  input logic [CW-1:0] count
);

  a_ctrl_known: assert property (@(posedge clk) disable iff (!rstn)
    !$isunknown({i_vld, o_rdy, flush}));

  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    count <= CW'(DP));

endmodule
`endif
`endif

module gnrl_fifo_buf #(
  parameter int DP = 4,
  parameter int DW = 32,
  parameter int CW = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] count
);

  // Pointer width; a single-entry FIFO still gets a 1-bit pointer held at 0.
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;

  logic [DW-1:0] mem_r [DP];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Advance a pointer by one with wrap at DP-1; DP need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (DP == 1) begin
      return {PW{1'b0}};
    end else if (ptr == PW'(DP - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Flags depend on the registered count only, keeping both sides decoupled.
  assign full_s  = (count_r == CW'(DP));
  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = i_vld & ~full_s;
  assign pop_s   = o_rdy & ~empty_s;

  assign i_rdy = ~full_s;
  assign o_vld = ~empty_s;
  assign o_dat = mem_r[rptr_r];
  assign count = count_r;

  // Next occupancy from the handshake pair; simultaneous push and pop cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush clears everything and wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Storage array, load-enabled and deliberately without reset; a write in a
  // flush cycle is suppressed since that data is discarded anyway.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wptr_r] <= i_dat;
    end
  end

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
  gnrl_fifo_buf_chk #(
    .DP (DP),
    .CW (CW)
  ) u_chk (
    .clk   (clk),
    .rstn  (rstn),
    .i_vld (i_vld),
    .o_rdy (o_rdy),
    .flush (flush),
    .count (count_r)
  );
`endif
`endif

endmodule
